return_ddr_writer: RTL and testbench

- Downstream consumer of the return buffer FIFO, which packs 8-bit results into 128-bit words.
- Drains 128-bit words from that FIFO and writes them to DDR as AXI4 write bursts, starting at a programmed base address.
- One task per layer output. Tasks are started by the layer controller, which receives a done pulse at completion.

---
 rtl/return_ddr_writer_pkg.sv | 20 ++
 rtl/return_ddr_writer_sizer.sv | 22 ++
 rtl/return_ddr_writer.sv | 137 +++++++++++++
 tb/tb_return_ddr_writer.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/return_ddr_writer_pkg.sv
// Shared types and AXI constants for the return-buffer DDR writer.
// Imported by the FSM top and its burst sizer.
package return_ddr_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [2:0] awsize_of(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/return_ddr_writer_sizer.sv
// Burst length and launch decision from the remaining word count and
// the FIFO fill flags.
module return_burst_sizer #(
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 20,
  parameter int BL_W      = 5
) (
  input  logic [LEN_W-1:0] remain,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  output logic [BL_W-1:0]  blen,
  output logic             fire
);

  logic full;

  assign full = remain >= LEN_W'(BURST_LEN);
  assign blen = full ? BL_W'(BURST_LEN) : remain[BL_W-1:0];
  // a full burst waits for a whole burst in the FIFO, a tail for any word
  assign fire = full ? !fifo_almost_empty : !fifo_empty;

endmodule

// File: rtl/return_ddr_writer.sv
// Drains 128-bit return-buffer words into DDR as single-outstanding
// AXI4 INCR write bursts, one task per layer output.
module return_ddr_writer
  import return_ddr_writer_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int LEN_W     = 20
) (
  input  logic                system_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    total_words,
  output logic                busy,
  output logic                done,
  output logic                resp_err,
  input  logic [DATA_W-1:0]   fifo_rddata,
  input  logic                fifo_empty,
  input  logic                fifo_almost_empty,
  output logic                fifo_rden,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int BL_W      = $clog2(BURST_LEN) + 1;
  localparam int BYTE_LSB  = $clog2(DATA_W / 8);
  localparam int ALIGN_LSB = $clog2(BURST_LEN * DATA_W / 8);

  state_t state;
  state_t state_nx;

  logic [ADDR_W-1:0] addr_rg;
  logic [LEN_W-1:0]  remain_rg;
  logic [BL_W-1:0]   beat_cnt;
  logic [BL_W-1:0]   blen_rg;
  logic [BL_W-1:0]   blen;
  logic              fire;
  logic              accept;
  logic              b_hs;
  logic              unused_addr_lsb;

  return_burst_sizer #(
    .BURST_LEN (BURST_LEN),
    .LEN_W     (LEN_W),
    .BL_W      (BL_W)
  ) u_sizer (
    .remain            (remain_rg),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .blen              (blen),
    .fire              (fire)
  );

  assign unused_addr_lsb = ^base_addr[ALIGN_LSB-1:0];

  assign accept = start && (state == S_IDLE);
  assign b_hs   = (state == S_RESP) && m_bvalid;

  assign busy      = state != S_IDLE;
  assign m_awvalid = state == S_ADDR;
  assign m_awaddr  = addr_rg;
  assign m_awlen   = 8'(blen_rg) - 8'd1;
  assign m_awsize  = awsize_of(DATA_W);
  assign m_awburst = BURST_INCR;
  assign m_wdata   = fifo_rddata;
  assign m_wstrb   = '1;
  // an empty FIFO just stalls the beat
  assign m_wvalid  = (state == S_DATA) && !fifo_empty;
  assign fifo_rden = m_wvalid && m_wready;
  assign m_wlast   = (state == S_DATA) && (beat_cnt == blen_rg - 1'b1);
  assign m_bready  = state == S_RESP;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start && total_words != '0) state_nx = S_WAIT;
      S_WAIT: if (fire) state_nx = S_ADDR;
      S_ADDR: if (m_awready) state_nx = S_DATA;
      S_DATA: if (fifo_rden && m_wlast) state_nx = S_RESP;
      S_RESP: if (m_bvalid) state_nx = (remain_rg != '0) ? S_WAIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      done      <= 1'b0;
      resp_err  <= 1'b0;
      addr_rg   <= '0;
      remain_rg <= '0;
      beat_cnt  <= '0;
      blen_rg   <= '0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (accept) begin
        resp_err <= 1'b0;
        if (total_words == '0) begin
          done <= 1'b1;
        end else begin
          // burst-aligned base keeps every burst inside one 4 KB page
          addr_rg   <= {base_addr[ADDR_W-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
          remain_rg <= total_words;
        end
      end
      if (state == S_WAIT && fire) blen_rg <= blen;
      if (state == S_ADDR && m_awready) beat_cnt <= '0;
      if (fifo_rden) begin
        beat_cnt <= beat_cnt + 1'b1;
        if (m_wlast) begin
          addr_rg   <= addr_rg + (ADDR_W'(blen_rg) << BYTE_LSB);
          remain_rg <= remain_rg - LEN_W'(blen_rg);
        end
      end
      if (b_hs) begin
        if (m_bresp != RESP_OKAY) resp_err <= 1'b1;
        if (remain_rg == '0) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_return_ddr_writer.sv
// Bench for return_ddr_writer: FIFO and AXI slave models, a burst
// reference built from the task parameters, vectors plus random tasks.
module tb_return_ddr_writer;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int LW = 20;

  logic            system_clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [LW-1:0]   total_words = '0;
  logic            busy;
  logic            done;
  logic            resp_err;
  logic [DW-1:0]   fifo_rddata = '0;
  logic            fifo_empty = 1'b1;
  logic            fifo_almost_empty = 1'b1;
  logic            fifo_rden;
  logic [AW-1:0]   m_awaddr;
  logic [7:0]      m_awlen;
  logic [2:0]      m_awsize;
  logic [1:0]      m_awburst;
  logic            m_awvalid;
  logic            m_awready = 1'b0;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_wlast;
  logic            m_wvalid;
  logic            m_wready = 1'b0;
  logic [1:0]      m_bresp = 2'b00;
  logic            m_bvalid = 1'b0;
  logic            m_bready;

  always #5 system_clk = ~system_clk;

  return_ddr_writer dut (
    .system_clk        (system_clk),
    .rst_n             (rst_n),
    .start             (start),
    .base_addr         (base_addr),
    .total_words       (total_words),
    .busy              (busy),
    .done              (done),
    .resp_err          (resp_err),
    .fifo_rddata       (fifo_rddata),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_rden         (fifo_rden),
    .m_awaddr          (m_awaddr),
    .m_awlen           (m_awlen),
    .m_awsize          (m_awsize),
    .m_awburst         (m_awburst),
    .m_awvalid         (m_awvalid),
    .m_awready         (m_awready),
    .m_wdata           (m_wdata),
    .m_wstrb           (m_wstrb),
    .m_wlast           (m_wlast),
    .m_wvalid          (m_wvalid),
    .m_wready          (m_wready),
    .m_bresp           (m_bresp),
    .m_bvalid          (m_bvalid),
    .m_bready          (m_bready)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [127:0] word_of(int k);
    return {32'(k), ~32'(k), 32'(k * 7 + 3), 32'hC0DE_0000 ^ 32'(k)};
  endfunction

  // FIFO model: one push per cycle up to push_target
  logic [127:0] fq[$];
  int push_idx = 0;
  int push_target = 0;
  int fifo_cnt = 0;

  always @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_cnt <= 0;
      fifo_empty <= 1'b1;
      fifo_almost_empty <= 1'b1;
      fifo_rddata <= '0;
    end else begin
      if (fifo_rden && fq.size() != 0) void'(fq.pop_front());
      if (push_idx < push_target) begin
        fq.push_back(word_of(push_idx));
        push_idx++;
      end
      fifo_cnt <= fq.size();
      fifo_empty <= fq.size() == 0;
      fifo_almost_empty <= fq.size() < BL;
      fifo_rddata <= (fq.size() != 0) ? fq[0] : '0;
    end
  end

  // monitor
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  bit          last_q[$];
  int pops = 0;
  int dones = 0;
  int b_cnt = 0;
  int exp_idx = 0;
  bit bpend = 0;
  bit prev_stall = 0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;

  always @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      bpend = 0;
      prev_stall = 0;
      exp_idx = push_idx;
    end else begin
      if (prev_stall) begin
        chk("aw_hold_valid", m_awvalid, 1);
        chk("aw_hold_addr", m_awaddr, prev_addr);
        chk("aw_hold_len", m_awlen, prev_len);
      end
      prev_stall = m_awvalid && !m_awready;
      prev_addr = m_awaddr;
      prev_len = m_awlen;
      if (m_awvalid && m_awready) begin
        aw_addr_q.push_back(m_awaddr);
        aw_len_q.push_back(m_awlen);
      end
      if (m_wvalid && m_wready) begin
        chk("wdata", m_wdata, word_of(exp_idx));
        exp_idx++;
        last_q.push_back(m_wlast);
        if (m_wlast) bpend = 1;
      end
      if (fifo_rden) begin
        pops++;
        chk("pop_nonempty", fifo_cnt != 0, 1);
      end
      if (m_bvalid && m_bready) begin
        b_cnt++;
        bpend = 0;
      end
      if (done) dones++;
    end
  end

  // AXI slave model, driven on the falling edge
  int aw_wait = 0;
  int cfg_aw_dly = 0;
  bit cfg_wr_rand = 0;
  int cfg_err_abs = -1;

  always @(negedge system_clk) begin
    if (!rst_n) begin
      m_awready = 1'b0;
      m_wready = 1'b0;
      m_bvalid = 1'b0;
      m_bresp = 2'b00;
      aw_wait = 0;
    end else begin
      m_awready = m_awvalid && aw_wait >= cfg_aw_dly;
      aw_wait = m_awvalid ? aw_wait + 1 : 0;
      m_wready = cfg_wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      m_bvalid = bpend;
      m_bresp = (bpend && b_cnt == cfg_err_abs) ? 2'b10 : 2'b00;
    end
  end

  task automatic run_task(
    input  logic [31:0] base,
    input  int          total,
    input  int          dly,
    input  bit          wrr,
    input  int          eb,
    input  bit          prefill,
    input  int          stall_at,
    input  bit          spurious,
    output logic [31:0] last_addr,
    output logic [7:0]  last_len,
    output int          nb,
    output bit          err
  );
    logic [31:0] ea[$];
    logic [7:0]  el[$];
    logic [31:0] a;
    int rem, blen, a0, l0, p0, d0, n, k, bad;
    bit exp_err;
    a = base & 32'hFFFF_FF00;
    rem = total;
    while (rem > 0) begin
      blen = rem > BL ? BL : rem;
      ea.push_back(a);
      el.push_back(8'(blen - 1));
      a = a + 32'(blen * 16);
      rem -= blen;
    end
    exp_err = eb >= 0 && eb < ea.size();
    cfg_aw_dly = dly;
    cfg_wr_rand = wrr;
    cfg_err_abs = eb < 0 ? -1 : b_cnt + eb;
    a0 = aw_addr_q.size();
    l0 = last_q.size();
    p0 = pops;
    d0 = dones;
    if (prefill) begin
      push_target += total;
      n = 0;
      while (fifo_cnt < total && n < 200) begin
        @(negedge system_clk);
        n++;
      end
    end else begin
      push_target += (stall_at > 0) ? stall_at : total;
    end
    @(negedge system_clk);
    start = 1'b1;
    base_addr = base;
    total_words = LW'(total);
    @(negedge system_clk);
    start = 1'b0;
    base_addr = $urandom;
    total_words = LW'($urandom);
    chk("err_cleared", resp_err, 0);
    chk("busy_after_start", busy, 1);
    if (prefill) begin
      chk("aw_not_yet", m_awvalid, 0);
      @(negedge system_clk);
      chk("start_to_awvalid", m_awvalid, 1);
    end
    if (spurious) begin
      @(negedge system_clk);
      start = 1'b1;
      base_addr = 32'hDEAD_BEEF;
      total_words = LW'(7);
      @(negedge system_clk);
      start = 1'b0;
    end
    if (stall_at > 0) begin
      n = 0;
      while (pops - p0 < stall_at && n < 500) begin
        @(negedge system_clk);
        n++;
      end
      chk("stall_reached", pops - p0, stall_at);
      repeat (5) begin
        @(negedge system_clk);
        chk("wvalid_underrun", m_wvalid, 0);
      end
      chk("beats_held", last_q.size() - l0, stall_at);
      push_target += total - stall_at;
    end
    n = 0;
    while (dones == d0 && n < 4000) begin
      @(negedge system_clk);
      n++;
    end
    repeat (3) @(negedge system_clk);
    chk("done_once", dones - d0, 1);
    chk("idle_after", busy, 0);
    chk("resp_err_final", resp_err, exp_err);
    chk("burst_count", aw_addr_q.size() - a0, ea.size());
    for (int i = 0; i < ea.size() && a0 + i < aw_addr_q.size(); i++) begin
      chk("awaddr", aw_addr_q[a0 + i], ea[i]);
      chk("awlen", aw_len_q[a0 + i], el[i]);
    end
    chk("beat_count", last_q.size() - l0, total);
    chk("pop_count", pops - p0, total);
    k = 0;
    bad = 0;
    for (int i = 0; i < el.size(); i++) begin
      for (int j = 0; j <= int'(el[i]); j++) begin
        if (l0 + k < last_q.size() && last_q[l0 + k] != (j == int'(el[i]))) bad++;
        k++;
      end
    end
    chk("wlast_pattern", bad, 0);
    nb = aw_addr_q.size() - a0;
    last_addr = nb > 0 ? aw_addr_q[aw_addr_q.size() - 1] : '0;
    last_len = nb > 0 ? aw_len_q[aw_len_q.size() - 1] : '0;
    err = resp_err;
  endtask

  typedef struct {
    logic [31:0] base;
    int          total;
    int          dly;
    bit          wrr;
    int          eb;
    bit          spur;
    int          exp_nb;
    logic [31:0] exp_last;
    logic [7:0]  exp_len;
    bit          exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] la;
    logic [7:0]  ll;
    int nb, a0, l0, d0, n;
    bit er;
    vecs[0] = '{32'h1000_0000, 32, 0, 0, -1, 1, 2, 32'h1000_0100, 8'd15, 0};
    vecs[1] = '{32'h1000_0000, 20, 0, 0, -1, 0, 2, 32'h1000_0100, 8'd3, 0};
    vecs[2] = '{32'h2000_0037, 5, 0, 0, -1, 0, 1, 32'h2000_0000, 8'd4, 0};
    vecs[3] = '{32'h3000_0000, 40, 7, 1, -1, 1, 3, 32'h3000_0200, 8'd7, 0};
    vecs[4] = '{32'h4000_0000, 48, 0, 0, 1, 0, 3, 32'h4000_0200, 8'd15, 1};
    vecs[5] = '{32'hFFFF_FF00, 20, 0, 1, -1, 0, 2, 32'h0000_0000, 8'd3, 0};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge system_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_rden", fifo_rden, 0);
    chk("awsize", m_awsize, 3'd4);
    chk("awburst", m_awburst, 2'b01);
    chk("wstrb", m_wstrb, 16'hFFFF);
    rst_n = 1'b1;
    @(negedge system_clk);

    foreach (vecs[i]) begin
      run_task(vecs[i].base, vecs[i].total, vecs[i].dly, vecs[i].wrr,
               vecs[i].eb, 1'b1, 0, vecs[i].spur, la, ll, nb, er);
      chk("vec_bursts", nb, vecs[i].exp_nb);
      chk("vec_last_addr", la, vecs[i].exp_last);
      chk("vec_last_len", ll, vecs[i].exp_len);
      chk("vec_resp_err", er, vecs[i].exp_err);
    end

    // zero-length task
    a0 = aw_addr_q.size();
    @(negedge system_clk);
    start = 1'b1;
    base_addr = 32'h1234_5678;
    total_words = '0;
    @(negedge system_clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    @(negedge system_clk);
    chk("zero_done_pulse", done, 0);
    chk("zero_busy2", busy, 0);
    chk("zero_no_aw", aw_addr_q.size() - a0, 0);

    // FIFO runs dry after 3 words of a 10-word tail burst
    run_task(32'h6000_0000, 10, 0, 0, -1, 1'b0, 3, 1'b0, la, ll, nb, er);
    chk("underrun_len", ll, 8'd9);

    // reset during beat 8 of a full burst
    push_target += 16;
    n = 0;
    while (fifo_cnt < 16 && n < 200) begin
      @(negedge system_clk);
      n++;
    end
    l0 = last_q.size();
    d0 = dones;
    cfg_aw_dly = 0;
    cfg_wr_rand = 0;
    @(negedge system_clk);
    start = 1'b1;
    base_addr = 32'h5000_0000;
    total_words = LW'(16);
    @(negedge system_clk);
    start = 1'b0;
    n = 0;
    while (last_q.size() - l0 < 7 && n < 200) begin
      @(negedge system_clk);
      n++;
    end
    chk("rst_pre_beats", last_q.size() - l0, 7);
    chk("rst_pre_wvalid", m_wvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", resp_err, 0);
    chk("mid_rst_awvalid", m_awvalid, 0);
    chk("mid_rst_wvalid", m_wvalid, 0);
    chk("mid_rst_bready", m_bready, 0);
    chk("mid_rst_rden", fifo_rden, 0);
    push_target = push_idx;
    repeat (2) @(negedge system_clk);
    rst_n = 1'b1;
    chk("mid_rst_no_done", dones - d0, 0);
    run_task(32'h5000_0000, 16, 0, 0, -1, 1'b1, 0, 1'b0, la, ll, nb, er);
    chk("post_rst_addr", la, 32'h5000_0000);

    // random tasks, streamed FIFO fill, random handshakes
    for (int r = 0; r < 6; r++) begin
      run_task($urandom, int'($urandom_range(1, 45)), int'($urandom_range(0, 3)),
               1'b1, int'($urandom_range(0, 3)) - 1, 1'b0, 0, r[0],
               la, ll, nb, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
